// File: rtl/mux4x1_arb_pkg.sv
// Shared types, sizes and the round-robin search used by the 4-way burst arbiter.
package mux4x1_arb_pkg;

   localparam int unsigned SRC_W   = 2;
   localparam int unsigned NUM_REQ = 4;

   typedef enum logic {
      IDLE,
      BURST
   } arb_state_t;

   // First set bit of req, searching ptr, ptr+1, ... modulo NUM_REQ.
   function automatic logic [SRC_W-1:0] rr_pick(input logic [SRC_W-1:0]   ptr,
                                                input logic [NUM_REQ-1:0] req);
      logic [SRC_W-1:0] idx;
      logic [SRC_W-1:0] win;
      logic             found;
      win   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = ptr + SRC_W'(i);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/mux4x1.sv
// Plain 4:1 mux; shared by the arbiter and its sibling operand muxes.
module mux4x1 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic [1:0]       sel,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic [WIDTH-1:0] d3,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = d0;
      case (sel)
         2'd1:    y = d1;
         2'd2:    y = d2;
         2'd3:    y = d3;
         default: y = d0;
      endcase
   end

endmodule

// File: rtl/mux4x1_rr_arbiter.sv
// Round-robin burst arbiter: grants one of four requesters per burst and steers
// its beats through a mux4x1 onto a registered valid/ready output.
module mux4x1_rr_arbiter
   import mux4x1_arb_pkg::*;
#(
   parameter int unsigned WIDTH     = 18,
   parameter int unsigned MAX_BEATS = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       in_valid,
   output logic [3:0]       in_ready,
   input  logic [3:0]       in_last,
   input  logic [WIDTH-1:0] in_data0,
   input  logic [WIDTH-1:0] in_data1,
   input  logic [WIDTH-1:0] in_data2,
   input  logic [WIDTH-1:0] in_data3,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic [1:0]       out_src,
   output logic [1:0]       sel,
   output logic             busy,
   output logic             err_overrun,
   input  logic             err_clr
);

   localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

   arb_state_t        state, state_nxt;
   logic [SRC_W-1:0]  ptr;
   logic [CNT_W-1:0]  cnt;
   logic [WIDTH:0]    mux_y;
   logic              cur_last;
   logic              can_take;
   logic              accept;
   logic              forced;
   logic              burst_end;

   // Data and last travel together so the end marker always matches the beat.
   mux4x1 #(.WIDTH(WIDTH + 1)) u_mux (
      .sel (sel),
      .d0  ({in_last[0], in_data0}),
      .d1  ({in_last[1], in_data1}),
      .d2  ({in_last[2], in_data2}),
      .d3  ({in_last[3], in_data3}),
      .y   (mux_y)
   );

   assign cur_last = mux_y[WIDTH];
   assign busy     = (state == BURST);

   always_comb begin
      in_ready  = '0;
      can_take  = (state == BURST) && (!out_valid || out_ready);
      if (can_take) in_ready[sel] = 1'b1;
      accept    = can_take && in_valid[sel];
      forced    = (cnt == CNT_W'(MAX_BEATS - 1)) && !cur_last;
      burst_end = accept && (cur_last || forced);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|in_valid) state_nxt = BURST;
         BURST:   if (burst_end) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel         <= '0;
         ptr         <= '0;
         cnt         <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_last    <= 1'b0;
         out_src     <= '0;
         err_overrun <= 1'b0;
      end else begin
         if (state == IDLE && |in_valid) begin
            sel <= rr_pick(ptr, in_valid);
            cnt <= '0;
         end
         if (accept) begin
            out_data  <= mux_y[WIDTH-1:0];
            out_last  <= cur_last || forced;
            out_src   <= sel;
            out_valid <= 1'b1;
            cnt       <= cnt + CNT_W'(1);
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (burst_end) ptr <= sel + SRC_W'(1);
         if (accept && forced) err_overrun <= 1'b1;
         else if (err_clr)     err_overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux4x1_rr_arbiter.sv
// Scoreboard bench for mux4x1_rr_arbiter: burst-level round-robin model feeds an
// expected-beat queue, a separate monitor checks every output handshake.
module tb_mux4x1_rr_arbiter;

   localparam int W  = 18;
   localparam int MB = 4;

   logic         clk, rst_n;
   logic [3:0]   in_valid, in_ready, in_last;
   logic [W-1:0] dat [4];
   logic [W-1:0] in_data0, in_data1, in_data2, in_data3;
   logic         out_valid, out_ready, out_last, busy, err_overrun, err_clr;
   logic [W-1:0] out_data;
   logic [1:0]   out_src, sel;

   assign in_data0 = dat[0];
   assign in_data1 = dat[1];
   assign in_data2 = dat[2];
   assign in_data3 = dat[3];

   mux4x1_rr_arbiter #(.WIDTH(W), .MAX_BEATS(MB)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .out_src(out_src), .sel(sel), .busy(busy),
      .err_overrun(err_overrun), .err_clr(err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed { logic [W-1:0] data; logic last; logic gap_ok; } sbeat_t;
   typedef struct packed { logic [1:0] src; logic [W-1:0] data; logic last; logic forced; } exp_t;

   sbeat_t drv_q  [4][$];
   exp_t   pend_q [4][$];
   exp_t   sb_q   [$];
   int     chunk_cnt [4];
   int     m_ptr, npops, cyc, last_pop, phase_pops;
   bit     m_err, rdy_rand, gaps_en, bubble_mode;
   int     tests, fails;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Chunking follows the forced-release rule: a burst is cut after MB beats without last.
   task automatic load_beat(input int r, input logic [W-1:0] d, input logic lst);
      exp_t   e;
      sbeat_t s;
      chunk_cnt[r]++;
      e.src    = 2'(r);
      e.data   = d;
      e.forced = !lst && (chunk_cnt[r] == MB);
      e.last   = lst || e.forced;
      s.data   = d;
      s.last   = lst;
      s.gap_ok = (chunk_cnt[r] > 1);
      if (e.last) chunk_cnt[r] = 0;
      drv_q[r].push_back(s);
      pend_q[r].push_back(e);
   endtask

   task automatic load_burst(input int r, input int n);
      for (int j = 0; j < n; j++) load_beat(r, W'($urandom), j == n - 1);
   endtask

   task automatic schedule();
      exp_t e;
      int   w;
      bit   any;
      any = 1'b1;
      while (any) begin
         any = 1'b0;
         w   = 0;
         for (int k = 0; k < 4; k++) begin
            if (!any && pend_q[(m_ptr + k) % 4].size() > 0) begin
               w   = (m_ptr + k) % 4;
               any = 1'b1;
            end
         end
         if (any) begin
            do begin
               e = pend_q[w].pop_front();
               sb_q.push_back(e);
            end while (!e.last && pend_q[w].size() > 0);
            m_ptr = (w + 1) % 4;
         end
      end
   endtask

   task automatic flush_model();
      sb_q.delete();
      for (int i = 0; i < 4; i++) begin
         drv_q[i].delete();
         pend_q[i].delete();
         chunk_cnt[i] = 0;
      end
      m_ptr = 0;
      m_err = 1'b0;
   endtask

   task automatic wait_drain(input int bound);
      int t;
      t = 0;
      while ((sb_q.size() != 0 || drv_q[0].size() != 0 || drv_q[1].size() != 0 ||
              drv_q[2].size() != 0 || drv_q[3].size() != 0) && t < bound) begin
         @(negedge clk);
         t++;
      end
      tests++;
      if (t >= bound) begin
         fails++;
         $display("FAIL drain_timeout: %0d beats still expected after %0d cycles", sb_q.size(), bound);
      end
      repeat (3) @(negedge clk);
      #1 chk("idle_after_drain", {out_valid, busy}, 2'b00);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_data"},  out_data, 0);
      chk({tag, "_out_last"},  out_last, 0);
      chk({tag, "_out_src"},   out_src, 0);
      chk({tag, "_sel"},       sel, 0);
      chk({tag, "_busy"},      busy, 0);
      chk({tag, "_in_ready"},  in_ready, 0);
      chk({tag, "_err"},       err_overrun, 0);
   endtask

   // Driver: holds each requester's front beat, pops it on an accepted handshake.
   initial begin
      logic [3:0] acc;
      in_valid  = '0;
      in_last   = '0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) dat[i] = '0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (rst_n && drv_q[i].size() > 0) begin
               in_valid[i] = !(gaps_en && drv_q[i][0].gap_ok && $urandom_range(0, 3) == 0);
               dat[i]      = drv_q[i][0].data;
               in_last[i]  = drv_q[i][0].last;
            end else begin
               in_valid[i] = 1'b0;
               in_last[i]  = 1'b0;
            end
         end
         out_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
         #4 acc = in_valid & in_ready;
         @(posedge clk);
         for (int i = 0; i < 4; i++)
            if (acc[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
      end
   end

   // Monitor: compares every output handshake with the scoreboard head.
   initial begin
      exp_t       e;
      bit         prev_stall, prev_busy;
      logic [W-1:0] p_data;
      logic       p_last;
      logic [1:0] p_src, p_sel;
      prev_stall = 1'b0;
      prev_busy  = 1'b0;
      forever begin
         @(negedge clk);
         #4;
         if (!rst_n) begin
            prev_stall = 1'b0;
            prev_busy  = 1'b0;
         end else begin
            cyc++;
            if (!$onehot0(in_ready)) chk("in_ready_onehot0", in_ready, 0);
            if (out_valid && !out_ready) chk("bp_in_ready", in_ready, 0);
            if (prev_stall) chk("bp_hold", {out_valid, out_last, out_src, out_data},
                                {1'b1, p_last, p_src, p_data});
            if (busy && prev_busy) chk("sel_stable", sel, p_sel);
            if (out_valid && out_ready) begin
               if (sb_q.size() == 0) begin
                  chk("unexpected_beat_src", out_src, 3'h4);
               end else begin
                  e = sb_q.pop_front();
                  if (e.forced) m_err = 1'b1;
                  chk("out_src",  out_src, e.src);
                  chk("out_data", out_data, e.data);
                  chk("out_last", out_last, e.last);
                  chk("err_overrun", err_overrun, m_err);
               end
               if (bubble_mode && phase_pops > 0) chk("burst_spacing", cyc - last_pop, 2);
               last_pop = cyc;
               phase_pops++;
               npops++;
            end
            prev_stall = out_valid && !out_ready;
            prev_busy  = busy;
            p_data = out_data; p_last = out_last; p_src = out_src; p_sel = sel;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, target;
      tests = 0; fails = 0; npops = 0; cyc = 0; last_pop = 0; phase_pops = 0;
      rdy_rand = 1'b0; gaps_en = 1'b0; bubble_mode = 1'b0;
      err_clr = 1'b0;
      rst_n   = 1'b0;
      flush_model();
      #12 check_reset_vals("reset");
      @(negedge clk) rst_n = 1'b1;

      // Single requester, fixed data, latency from first visible request.
      @(posedge clk);
      load_beat(2, 18'h00011, 1'b0);
      load_beat(2, 18'h00022, 1'b0);
      load_beat(2, 18'h00033, 1'b1);
      schedule();
      @(negedge clk);
      #2 chk("idle_in_ready", in_ready, 0);
      lat = 0;
      while (!out_valid && lat < 10) begin
         @(negedge clk);
         #2 lat++;
         if (lat == 1) chk("grant_sel", {busy, sel}, 3'b110);
      end
      chk("first_beat_latency", lat, 2);
      wait_drain(200);

      // Overrun: 7 beats from requester 1 (last only on 7th) competing with requester 2.
      @(posedge clk);
      for (int j = 0; j < 7; j++) load_beat(1, W'($urandom), j == 6);
      load_burst(2, 2);
      schedule();
      wait_drain(200);
      chk("err_sticky", err_overrun, 1);
      @(negedge clk) err_clr = 1'b1;
      @(negedge clk) err_clr = 1'b0;
      m_err = 1'b0;
      #1 chk("err_cleared", err_overrun, 0);

      // Preemption attempt: requester 0 arrives while requester 3 is mid-burst.
      @(posedge clk);
      for (int j = 0; j < 4; j++) load_beat(3, W'($urandom), j == 3);
      schedule();
      target = npops + 1;
      for (int t = 0; t < 50 && npops < target; t++) @(posedge clk);
      load_burst(0, 2);
      schedule();
      wait_drain(200);

      // Randomized traffic with backpressure and mid-burst valid gaps.
      rdy_rand = 1'b1;
      gaps_en  = 1'b1;
      for (int rnd = 0; rnd < 6; rnd++) begin
         @(posedge clk);
         for (int r = 0; r < 4; r++)
            for (int b = $urandom_range(0, 2); b > 0; b--) load_burst(r, $urandom_range(1, 6));
         schedule();
         wait_drain(3000);
      end
      rdy_rand = 1'b0;
      gaps_en  = 1'b0;

      // Reset in the middle of a burst, then restart from pointer 0.
      @(posedge clk);
      for (int j = 0; j < 4; j++) load_beat(1, W'($urandom), j == 3);
      schedule();
      target = npops + 2;
      for (int t = 0; t < 50 && npops < target; t++) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_vals("async_reset");
      flush_model();
      load_burst(3, 1);
      load_burst(2, 2);
      schedule();
      @(negedge clk) rst_n = 1'b1;
      wait_drain(200);

      // Fairness after reset: continuous 1-beat bursts from all four requesters.
      @(negedge clk) rst_n = 1'b0;
      flush_model();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 2; k++)
         for (int r = 0; r < 4; r++) load_burst(r, 1);
      schedule();
      phase_pops  = 0;
      bubble_mode = 1'b1;
      wait_drain(200);
      bubble_mode = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
